// File: rtl/rapids_mem_pkg.sv
// rapids_mem_pkg: shared FSM state type, requester IDs and default limits for the memory-port arbiter
package rapids_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic GNT_INSTR = 1'b0;
   localparam logic GNT_DATA  = 1'b1;

   localparam logic [31:0] INSTR_LIMIT_DEF = 32'h0000_4000;
   localparam logic [31:0] DATA_LIMIT_DEF  = 32'h0001_0000;
   localparam int          TIMEOUT_DEF     = 255;

   // watchdog counter width: wide enough for the timeout value, never below 8 bits
   function automatic int cnt_width(input int t);
      return ($clog2(t + 1) > 8) ? $clog2(t + 1) : 8;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin pick; the last-grant history lives in the parent
module rr_arbiter2
   import rapids_mem_pkg::*;
(
   input  logic       req_i,
   input  logic       req_d,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   logic pick_d;

   // data wins when alone, or under contention when instruction was granted last
   assign pick_d = req_d & (~req_i | (last_grant == GNT_INSTR));
   assign gnt    = {pick_d, req_i & ~pick_d};

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store; optional MEM_TIMEOUT_EN adds a BUSY watchdog
module mem_port_arbiter
   import rapids_mem_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] INSTR_LIMIT = ADDR_W'(INSTR_LIMIT_DEF),
   parameter logic [ADDR_W-1:0] DATA_LIMIT  = ADDR_W'(DATA_LIMIT_DEF),
   parameter int                TIMEOUT     = TIMEOUT_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_req,
   input  logic [ADDR_W-1:0] instr_addr,
   output logic              instr_ack,
   output logic [DATA_W-1:0] instr_rdata,
   output logic              instr_segv,
   output logic              wait_instr,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_ack,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_segv,
   output logic              wait_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                iack_q, iack_d;
   logic                dack_q, dack_d;
   logic                isegv_q, isegv_d;
   logic                dsegv_q, dsegv_d;
   logic [DATA_W-1:0]   irdata_q, irdata_d;
   logic [DATA_W-1:0]   drdata_q, drdata_d;
   logic [1:0]          gnt;
   logic                i_fault, d_fault;
   logic                expire;

   rr_arbiter2 u_arb (
      .req_i      (instr_req),
      .req_d      (data_req),
      .last_grant (last_q),
      .gnt        (gnt)
   );

   assign i_fault = instr_addr >= INSTR_LIMIT;
   assign d_fault = data_addr >= DATA_LIMIT;

`ifdef MEM_TIMEOUT_EN
   localparam int CW = cnt_width(TIMEOUT);
   logic [CW-1:0] cnt_q, cnt_d;

   // a late mem_ack in the final cycle still completes normally
   assign expire = ~mem_ack & (cnt_q == CW'(TIMEOUT - 1));

   // watchdog clears on entry to BUSY and counts BUSY cycles spent waiting
   always_comb begin
      cnt_d = (state_q == IDLE) ? '0 : (state_q == BUSY_I || state_q == BUSY_D) ? cnt_q + CW'(1) : cnt_q;
   end

   // watchdog register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   // no watchdog: BUSY waits on mem_ack indefinitely
   assign expire = (TIMEOUT < 0);
`endif

   // next-state and registered-output computation for the arbitration FSM
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      iack_d      = 1'b0;
      dack_d      = 1'b0;
      isegv_d     = 1'b0;
      dsegv_d     = 1'b0;
      irdata_d    = '0;
      drdata_d    = '0;
      case (state_q)
         IDLE: begin
            if (instr_req && data_req) last_d = gnt[GNT_DATA] ? GNT_DATA : GNT_INSTR;
            if (gnt[GNT_INSTR]) begin
               if (i_fault) begin
                  state_d = DONE;
                  iack_d  = 1'b1;
                  isegv_d = 1'b1;
               end else begin
                  state_d     = BUSY_I;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = instr_addr;
                  mem_wdata_d = '0;
               end
            end else if (gnt[GNT_DATA]) begin
               if (d_fault) begin
                  state_d = DONE;
                  dack_d  = 1'b1;
                  dsegv_d = 1'b1;
               end else begin
                  state_d     = BUSY_D;
                  mem_req_d   = 1'b1;
                  mem_we_d    = data_we;
                  mem_addr_d  = data_addr;
                  mem_wdata_d = data_wdata;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack || expire) begin
               mem_req_d = 1'b0;
               state_d   = DONE;
               if (state_q == BUSY_I) begin
                  iack_d   = 1'b1;
                  isegv_d  = ~mem_ack;
                  irdata_d = mem_ack ? mem_rdata : '0;
               end else begin
                  dack_d   = 1'b1;
                  dsegv_d  = ~mem_ack;
                  drdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and registered outputs; reset abandons any in-flight access at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= GNT_DATA;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         iack_q      <= 1'b0;
         dack_q      <= 1'b0;
         isegv_q     <= 1'b0;
         dsegv_q     <= 1'b0;
         irdata_q    <= '0;
         drdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         iack_q      <= iack_d;
         dack_q      <= dack_d;
         isegv_q     <= isegv_d;
         dsegv_q     <= dsegv_d;
         irdata_q    <= irdata_d;
         drdata_q    <= drdata_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign instr_ack   = iack_q;
   assign instr_segv  = isegv_q;
   assign instr_rdata = irdata_q;
   assign data_ack    = dack_q;
   assign data_segv   = dsegv_q;
   assign data_rdata  = drdata_q;
   assign wait_instr  = instr_req & ~iack_q;
   assign wait_data   = data_req & ~dack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;

   localparam logic [31:0] ILIM = 32'h0000_4000;
   localparam logic [31:0] DLIM = 32'h0001_0000;
`ifdef MEM_TIMEOUT_EN
   localparam int TO    = 3;
   localparam bit TO_ON = 1'b1;
   localparam int SD    = 2;
`else
   localparam int TO    = 255;
   localparam bit TO_ON = 1'b0;
   localparam int SD    = 4;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_req, instr_ack, instr_segv, wait_instr;
   logic [31:0] instr_addr, instr_rdata;
   logic        data_req, data_we, data_ack, data_segv, wait_data;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
      .instr_rdata(instr_rdata), .instr_segv(instr_segv), .wait_instr(wait_instr),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_ack(data_ack), .data_rdata(data_rdata), .data_segv(data_segv), .wait_data(wait_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // transaction-level model: who owns the port, how long it has waited, who is preferred next
   logic        e_mreq, e_mwe, e_iack, e_dack, e_isegv, e_dsegv;
   logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;
   bit          owner_data, prefer_data;
   int          waited;
   wire         take_d = data_req && (!instr_req || prefer_data);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         {e_mreq, e_mwe, e_iack, e_dack, e_isegv, e_dsegv} <= '0;
         e_maddr <= 0; e_mwdata <= 0; e_irdata <= 0; e_drdata <= 0;
         owner_data <= 0; prefer_data <= 0; waited <= 0;
      end else if (e_iack || e_dack) begin
         {e_iack, e_dack, e_isegv, e_dsegv} <= '0;
         e_irdata <= 0; e_drdata <= 0;
      end else if (e_mreq) begin
         if (mem_ack) begin
            e_mreq <= 0;
            if (owner_data) begin e_dack <= 1; e_drdata <= e_mwe ? 32'h0 : mem_rdata; end
            else begin e_iack <= 1; e_irdata <= mem_rdata; end
         end else if (TO_ON && waited == TO - 1) begin
            e_mreq <= 0;
            if (owner_data) begin e_dack <= 1; e_dsegv <= 1; end
            else begin e_iack <= 1; e_isegv <= 1; end
         end else waited <= waited + 1;
      end else if (instr_req || data_req) begin
         owner_data <= take_d;
         waited <= 0;
         if (instr_req && data_req) prefer_data <= !take_d;
         if (take_d ? data_addr >= DLIM : instr_addr >= ILIM) begin
            if (take_d) begin e_dack <= 1; e_dsegv <= 1; end
            else begin e_iack <= 1; e_isegv <= 1; end
         end else begin
            e_mreq   <= 1;
            e_mwe    <= take_d && data_we;
            e_maddr  <= take_d ? data_addr : instr_addr;
            e_mwdata <= take_d ? data_wdata : 32'h0;
         end
      end
   end

   // compare every output against the model mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         check("mem_req", mem_req, e_mreq);
         check("mem_we", mem_we, e_mwe);
         check("mem_addr", mem_addr, e_maddr);
         check("mem_wdata", mem_wdata, e_mwdata);
         check("instr_ack", instr_ack, e_iack);
         check("instr_segv", instr_segv, e_isegv);
         check("instr_rdata", instr_rdata, e_irdata);
         check("data_ack", data_ack, e_dack);
         check("data_segv", data_segv, e_dsegv);
         check("data_rdata", data_rdata, e_drdata);
         check("wait_instr", wait_instr, instr_req & ~e_iack);
         check("wait_data", wait_data, data_req & ~e_dack);
      end
   end

   function automatic logic [31:0] pick_addr(input logic [31:0] lim);
      case ($urandom_range(7))
         0: return lim;
         1: return lim - 32'd4;
         2: return lim + ($urandom & 32'hFFFF);
         3: return $urandom;
         default: return ($urandom % lim) & 32'hFFFF_FFFC;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int nack;
      int seq[4];
      int at[4];
      int dly;
      instr_req = 0; instr_addr = 0;
      data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0;
      mem_ack = 0; mem_rdata = 0;
      repeat (3) tick();
      check("rst_mem_req", mem_req, 0);
      check("rst_instr_ack", instr_ack, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_data_rdata", data_rdata, 0);
      rst = 0;
      tick();
      // single fetch, zero-wait memory
      mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; instr_req = 1; instr_addr = 32'h10;
      #1 check("t1_wait_c0", wait_instr, 1);
      check("t1_mreq_c0", mem_req, 0);
      tick();
      check("t1_mreq_c1", mem_req, 1);
      check("t1_maddr_c1", mem_addr, 32'h10);
      check("t1_wait_c1", wait_instr, 1);
      tick();
      check("t1_ack_c2", instr_ack, 1);
      check("t1_rdata_c2", instr_rdata, 32'hDEAD_BEEF);
      check("t1_wait_c2", wait_instr, 0);
      check("t1_mreq_c2", mem_req, 0);
      instr_req = 0;
      tick();
      check("t1_ack_c3", instr_ack, 0);
      // contention from reset
      rst = 1;
      instr_req = 1; instr_addr = 32'h20; data_req = 1; data_we = 0; data_addr = 32'h40;
      tick();
      rst = 0;
      nack = 0;
      for (int c = 0; c < 20 && nack < 4; c++) begin
         tick();
         if (instr_ack || data_ack) begin
            seq[nack] = int'(data_ack);
            at[nack] = c;
            nack++;
         end
      end
      instr_req = 0; data_req = 0; mem_ack = 0;
      check("t2_ack_count", nack, 4);
      for (int k = 0; k < 4 && k < nack; k++) check($sformatf("t2_who%0d", k), seq[k], k % 2);
      for (int k = 1; k < 4 && k < nack; k++) check($sformatf("t2_gap%0d", k), at[k] - at[k-1], 3);
      tick();
      // store with delayed mem_ack
      data_req = 1; data_we = 1; data_addr = 32'h100; data_wdata = 32'h55; mem_ack = 0;
      tick();
      for (int k = 0; k < SD; k++) begin
         check("t3_mreq", mem_req, 1);
         check("t3_mwe", mem_we, 1);
         check("t3_mwdata", mem_wdata, 32'h55);
         check("t3_dack_early", data_ack, 0);
         tick();
      end
      check("t3_mreq_last", mem_req, 1);
      mem_ack = 1;
      tick();
      check("t3_dack", data_ack, 1);
      check("t3_drdata", data_rdata, 0);
      check("t3_mreq_drop", mem_req, 0);
      data_req = 0; mem_ack = 0;
      tick();
      check("t3_dack_clear", data_ack, 0);
      // fetch fault and data boundary
      instr_req = 1; instr_addr = 32'h4000;
      tick();
      check("t4_isegv", instr_segv, 1);
      check("t4_iack", instr_ack, 1);
      check("t4_mreq", mem_req, 0);
      instr_req = 0;
      tick();
      data_req = 1; data_we = 0; data_addr = 32'hFFFC; mem_ack = 1;
      tick();
      check("t4_dedge_mreq", mem_req, 1);
      tick();
      check("t4_dedge_ack", data_ack, 1);
      check("t4_dedge_segv", data_segv, 0);
      check("t4_dedge_rdata", data_rdata, 32'hDEAD_BEEF);
      data_addr = 32'h1_0000;
      tick();
      tick();
      check("t4_dlim_segv", data_segv, 1);
      check("t4_dlim_rdata", data_rdata, 0);
      data_req = 0; mem_ack = 0;
      tick();
      // reset in the middle of a load
      data_req = 1; data_we = 0; data_addr = 32'h200;
      tick();
      check("t5_mreq_busy", mem_req, 1);
      #2 rst = 1;
      #1 check("t5_mreq_async", mem_req, 0);
      check("t5_no_dack", data_ack, 0);
      tick();
      rst = 0; mem_ack = 1; mem_rdata = 32'h1234_5678;
      tick();
      check("t5_regrant", mem_req, 1);
      check("t5_regrant_addr", mem_addr, 32'h200);
      tick();
      check("t5_dack", data_ack, 1);
      check("t5_drdata", data_rdata, 32'h1234_5678);
      data_req = 0; mem_ack = 0;
      tick();
      // memory that never answers
      data_req = 1; data_we = 0; data_addr = 32'h300;
`ifdef MEM_TIMEOUT_EN
      tick();
      check("t6_mreq_c1", mem_req, 1);
      tick();
      tick();
      check("t6_mreq_c3", mem_req, 1);
      check("t6_dack_c3", data_ack, 0);
      tick();
      check("t6_segv", data_segv, 1);
      check("t6_dack", data_ack, 1);
      check("t6_mreq_drop", mem_req, 0);
      check("t6_rdata", data_rdata, 0);
      data_req = 0;
      tick();
`else
      for (int k = 0; k < 100; k++) begin
         tick();
         check("t6_stall_mreq", mem_req, 1);
         check("t6_stall_dack", data_ack, 0);
      end
      rst = 1; data_req = 0;
      tick();
      rst = 0;
      tick();
`endif
      // randomized traffic
      dly = -1;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (c % 700 == 350) begin
            #2 rst = 1;
            #1 check("rnd_rst_mreq", mem_req, 0);
            tick();
            rst = 0; instr_req = 0; data_req = 0; mem_ack = 0; dly = -1;
            continue;
         end
         if (!instr_req || instr_ack) begin
            instr_req = $urandom_range(9) < 6;
            instr_addr = pick_addr(ILIM);
         end
         if (!data_req || data_ack) begin
            data_req = $urandom_range(9) < 6;
            data_we = 1'($urandom_range(1));
            data_addr = pick_addr(DLIM);
            data_wdata = $urandom;
         end
         if (mem_req) begin
            if (dly < 0) dly = $urandom_range(2);
            mem_ack = (dly == 0);
            dly--;
         end else begin
            dly = -1;
            mem_ack = ($urandom_range(4) == 0);
         end
         mem_rdata = $urandom;
      end
      instr_req = 0; data_req = 0; mem_ack = 0;
      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between instruction fetch and data load/store requesters of the core.
- Generates the `wait_instr`/`wait_data` stalls and the `instr_segv`/`data_segv` faults consumed by the core FSM.
- Arbitration is 2-way round-robin; one memory transaction is outstanding at a time; memory latency is variable.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- INSTR_LIMIT, 32'h0000_4000, instruction addresses >= this fault.
- DATA_LIMIT, 32'h0001_0000, data addresses >= this fault.
- TIMEOUT, 255, max cycles awaiting `mem_ack` (only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_req  in  1  fetch request; held high with stable address until `instr_ack`.
- instr_addr  in  ADDR_W  fetch address.
- instr_ack  out  1  one-cycle completion pulse.
- instr_rdata  out  DATA_W  fetched word; valid while `instr_ack`.
- instr_segv  out  1  one-cycle fault pulse, coincident with `instr_ack`.
- wait_instr  out  1  combinational: `instr_req & ~instr_ack`.
- data_req  in  1  load/store request; held high with stable fields until `data_ack`.
- data_we  in  1  1 = store.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_ack  out  1  one-cycle completion pulse.
- data_rdata  out  DATA_W  load data; 0 for stores and faults.
- data_segv  out  1  one-cycle fault pulse, coincident with `data_ack`.
- wait_data  out  1  combinational: `data_req & ~data_ack`.
- mem_req  out  1  registered; held until `mem_ack`.
- mem_we  out  1  registered write enable.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  read data; valid with `mem_ack`.
- mem_ack  in  1  transaction complete; may assert in the first cycle of `mem_req`.

Behaviour:
- Reset values: state = IDLE, `last_grant` = DATA. All registered outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, both acks, both rdata, both segv.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant it.
- IDLE, both requests: grant the requester that is not `last_grant`; update `last_grant` to the winner.
- Granted address in range: latch address/data into the `mem_*` registers, set `mem_req` = 1, and go to BUSY_I or BUSY_D.
- Granted address >= its limit: no memory access. Go to DONE with segv = 1, ack = 1 and rdata = 0.
- BUSY_x with `mem_ack` = 1:
  - `mem_req` drops next cycle.
  - `x_rdata` captures `mem_rdata` (loads/fetches only).
  - `x_ack` is set and the state goes to DONE.
- BUSY_x with `mem_ack` = 0: hold everything.
- DONE: acks and segv are high for exactly this cycle, then cleared; always returns to IDLE. The DONE cycle stops a still-high `req` from being re-granted in the cycle its requester sees the ack.
- Latency: request at cycle 0 gives `mem_req` at cycle 1. A zero-wait `mem_ack` at cycle 1 gives ack at cycle 2. Back-to-back accesses cost 3 cycles each minimum.
- Fault latency: segv/ack at cycle 1.
- `mem_ack` outside BUSY states is ignored.
- A request dropped before its ack is a protocol violation; behaviour is undefined.
- `rst` mid-transaction: `mem_req` drops immediately (asynchronously), state returns to IDLE, and no ack is issued. The memory must abandon the in-flight access.
- Address comparison is unsigned, full ADDR_W.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter (width covers TIMEOUT) clears on entry to BUSY_x and increments each BUSY cycle without `mem_ack`.
  - On reaching TIMEOUT, `mem_req` drops and the state goes to DONE with `x_segv` = 1, `x_ack` = 1 and rdata = 0.
  - `mem_ack` in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Package `rapids_mem_pkg` holds:
  - the state enum (IDLE, BUSY_I, BUSY_D, DONE);
  - requester ID constants GNT_INSTR = 0 and GNT_DATA = 1;
  - the default limit constants.
- Sub-module `rr_arbiter2`: takes two requests plus `last_grant` and gives a one-hot grant. It is purely combinational; `last_grant` stays in the parent.

Test Plan:
- Single fetch, `mem_ack` tied 1, `instr_addr` = 0x10, `mem_rdata` = 0xDEADBEEF:
  - `mem_req` at cycle 1;
  - `instr_ack` and `instr_rdata` = 0xDEADBEEF at cycle 2;
  - `wait_instr` high for cycles 0–1 only.
- Both requests held continuously from reset, `mem_ack` = 1:
  - grants alternate I, D, I, D;
  - first grant is instruction; ack every 3 cycles.
- Store with `data_addr` = 0x100, `data_wdata` = 0x55, `mem_ack` delayed 4 cycles:
  - `mem_we` = 1 and `mem_wdata` = 0x55 held stable for 4 cycles;
  - `data_ack` one cycle after `mem_ack`; `data_rdata` = 0.
- Fetch at `instr_addr` = 0x4000: `instr_segv` and `instr_ack` at cycle 1, `mem_req` never asserted.
- `rst` pulsed while in BUSY_D: `mem_req` drops in the same cycle, no `data_ack`, next request is served normally.
- With MEM_TIMEOUT_EN and TIMEOUT = 3, `mem_ack` = 0: `data_segv` plus `data_ack` after 3 BUSY cycles and `mem_req` deasserted; without the macro, the block stays in BUSY for 100 cycles.
